load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 30 +++
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the load/store unit: FSM states, memory
// funct3 encodings and the request legality check.
package riscv_pkg;

  localparam int RV_XLEN      = 32;
  localparam int LSU_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_funct3_t;

  // Stores share the size encodings of the signed loads.
  localparam mem_funct3_t SB = LB;
  localparam mem_funct3_t SH = LH;
  localparam mem_funct3_t SW = LW;

  // A request is legal when exactly one of read/write is set, the size is
  // valid for the direction, and the address is naturally aligned.
  function automatic logic access_legal(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = rd ^ wr;
    case (f3)
      LB:      ok = ok;
      LH:      ok = ok & ~off[0];
      LW:      ok = ok & (off == 2'b00);
      LBU:     ok = ok & rd;
      LHU:     ok = ok & rd & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load data extraction: picks the addressed byte/halfword lane out of the
// bus word and sign- or zero-extends it according to funct3.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[8*offset +: 8];
    half_lane = rdata[16*offset[1] +: 16];
    data      = rdata;
    case (funct3)
      LB:      data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LBU:     data = {{(XLEN-8){1'b0}}, byte_lane};
      LH:      data = {{(XLEN-16){half_lane[15]}}, half_lane};
      LHU:     data = {{(XLEN-16){1'b0}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns pipeline MemRead/MemWrite requests into single
// bus transactions with byte lanes, timeout and aligned load data.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN     = RV_XLEN,
  parameter int MAX_WAIT = LSU_MAX_WAIT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] StoreData,
  output logic [XLEN-1:0] ReadDataMem,
  output logic            LoadValid,
  output logic            Stall,
  output logic            AccessErr,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic             is_load_q, is_load_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             load_valid_q, load_valid_d;
  logic             err_q, err_d;
  logic             bus_req_q, bus_req_d;

  logic             req_any;
  logic             req_legal;
  logic             timeout;
  logic [3:0]       be_new;
  logic [XLEN-1:0]  wdata_new;
  logic [XLEN-1:0]  aligned_data;

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .rdata (bus_rdata),
    .offset(off_q),
    .funct3(f3_q),
    .data  (aligned_data)
  );

  assign req_any   = MemRead | MemWrite;
  assign req_legal = access_legal(MemRead, MemWrite, Funct3, Addr[1:0]);
  assign timeout   = (cnt_q == CNT_LAST);

  // Narrow stores replicate their data to every lane so the slave can pick
  // whichever lane the byte enables select.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = StoreData;
    case (Funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << Addr[1:0];
        wdata_new = {(XLEN/8){StoreData[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << Addr[1:0];
        wdata_new = {(XLEN/16){StoreData[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = StoreData;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    off_d        = off_q;
    f3_d         = f3_q;
    is_load_d    = is_load_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rdata_d      = rdata_q;
    load_valid_d = 1'b0;
    err_d        = 1'b0;
    bus_req_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_legal) begin
          addr_d    = {Addr[XLEN-1:2], 2'b00};
          off_d     = Addr[1:0];
          f3_d      = Funct3;
          is_load_d = MemRead;
          wdata_d   = MemWrite ? wdata_new : '0;
          be_d      = be_new;
          cnt_d     = '0;
          bus_req_d = 1'b1;
          state_d   = REQ;
        end else if (req_any) begin
          err_d = 1'b1;
        end
      end

      REQ: begin
        cnt_d = cnt_q + CNT_ONE;
        if (bus_gnt) begin
          state_d = is_load_q ? WAIT : DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          bus_req_d = 1'b1;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (bus_rvalid) begin
          rdata_d      = aligned_data;
          load_valid_d = 1'b1;
          state_d      = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      is_load_q    <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata_q      <= '0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
      bus_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      is_load_q    <= is_load_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rdata_q      <= rdata_d;
      load_valid_q <= load_valid_d;
      err_q        <= err_d;
      bus_req_q    <= bus_req_d;
    end
  end

  // Stall must see a legal request in the same cycle it is presented, so it
  // is the one output decoded combinationally.
  assign Stall = ((state_q == IDLE) && req_legal) || (state_q == REQ) || (state_q == WAIT);

  assign ReadDataMem = rdata_q;
  assign LoadValid   = load_valid_q;
  assign AccessErr   = err_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_req_q & ~is_load_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_be      = be_q;

endmodule
